// File: rtl/avr_io_master.sv
// Byte-serial command channel to single-cycle AVR I/O bus accesses, with read data returned as a byte stream.
// Paired accesses keep temp-register order: read low then high, write high then low.
module avr_io_master #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [7:0]    rsp_data,
  output logic          io_re,
  output logic          io_we,
  output logic [AW-1:0] io_a,
  output logic [7:0]    io_wd,
  input  logic [7:0]    io_rd
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GETD = 3'd1,
    WR1  = 3'd2,
    WR2  = 3'd3,
    RD1  = 3'd4,
    RD2  = 3'd5,
    RSP  = 3'd6
  } state_t;

  localparam logic [AW-1:0] A_ONE = AW'(1);

  state_t        state;
  logic          pair;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_inc;
  logic [7:0]    lo;
  logic [7:0]    hi;
  logic          got_lo;
  logic          rsp_hi;

  assign addr_inc = addr + A_ONE;

  // Every output is a register; strobe values are loaded on the edge that
  // enters the strobe state so they line up with that state's cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      pair      <= 1'b0;
      addr      <= '0;
      lo        <= 8'h00;
      hi        <= 8'h00;
      got_lo    <= 1'b0;
      rsp_hi    <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      io_re     <= 1'b0;
      io_we     <= 1'b0;
      io_a      <= '0;
      io_wd     <= 8'h00;
    end else begin
      io_re <= 1'b0;
      io_we <= 1'b0;
      io_a  <= '0;
      io_wd <= 8'h00;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            pair   <= cmd_data[6];
            addr   <= cmd_data[AW-1:0];
            got_lo <= 1'b0;
            if (cmd_data[7]) begin
              state <= GETD;
            end else begin
              state     <= RD1;
              cmd_ready <= 1'b0;
              io_re     <= 1'b1;
              io_a      <= cmd_data[AW-1:0];
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        GETD: begin
          if (cmd_valid) begin
            if (pair && !got_lo) begin
              lo     <= cmd_data;
              got_lo <= 1'b1;
            end else begin
              // Last data byte goes straight onto the bus for the first strobe.
              if (pair) hi <= cmd_data;
              else      lo <= cmd_data;
              state     <= WR1;
              cmd_ready <= 1'b0;
              io_we     <= 1'b1;
              io_a      <= pair ? addr_inc : addr;
              io_wd     <= cmd_data;
            end
          end
        end
        WR1: begin
          if (pair) begin
            state <= WR2;
            io_we <= 1'b1;
            io_a  <= addr;
            io_wd <= lo;
          end else begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end
        end
        WR2: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        RD1: begin
          lo <= io_rd;
          if (pair) begin
            state <= RD2;
            io_re <= 1'b1;
            io_a  <= addr_inc;
          end else begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_data  <= io_rd;
            rsp_hi    <= 1'b0;
          end
        end
        RD2: begin
          hi        <= io_rd;
          state     <= RSP;
          rsp_valid <= 1'b1;
          rsp_data  <= lo;
          rsp_hi    <= 1'b0;
        end
        RSP: begin
          if (rsp_ready) begin
            if (pair && !rsp_hi) begin
              rsp_hi   <= 1'b1;
              rsp_data <= hi;
            end else begin
              state     <= IDLE;
              rsp_valid <= 1'b0;
              rsp_data  <= 8'h00;
              rsp_hi    <= 1'b0;
              cmd_ready <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_data  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avr_io_master.sv
// Directed and randomized checks of avr_io_master against a bus-level reference of peripheral behaviour.
module tb_avr_io_master;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       io_re;
  logic       io_we;
  logic [5:0] io_a;
  logic [7:0] io_wd;
  logic [7:0] io_rd;

  avr_io_master #(.AW(6)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .io_re(io_re), .io_we(io_we), .io_a(io_a), .io_wd(io_wd), .io_rd(io_rd)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Peripheral bus model: a=0/1 is a 16-bit timer with a shared temp register, the rest is plain memory.
  logic [15:0] tcnt = 16'h0000;
  logic [7:0]  ttemp = 8'h00;
  logic [7:0]  pmem [64];

  always_comb begin
    io_rd = pmem[io_a];
    if (io_a == 6'd0)      io_rd = tcnt[7:0];
    else if (io_a == 6'd1) io_rd = ttemp;
  end

  always @(posedge clk) begin
    if (io_we) begin
      if (io_a == 6'd1)      ttemp <= io_wd;
      else if (io_a == 6'd0) tcnt <= {ttemp, io_wd};
      else                   pmem[io_a] <= io_wd;
    end
    if (io_re && io_a == 6'd0) ttemp <= tcnt[15:8];
  end

  // Reference: same peripheral semantics applied to the access list the command implies.
  logic [15:0] r_tcnt = 16'h0000;
  logic [7:0]  r_temp = 8'h00;
  logic [7:0]  r_mem [64];

  function automatic void ref_wr(input logic [5:0] a, input logic [7:0] d);
    if (a == 6'd1)      r_temp = d;
    else if (a == 6'd0) r_tcnt = {r_temp, d};
    else                r_mem[a] = d;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [5:0] a);
    logic [7:0] v;
    v = r_mem[a];
    if (a == 6'd0) begin
      v = r_tcnt[7:0];
      r_temp = r_tcnt[15:8];
    end else if (a == 6'd1) begin
      v = r_temp;
    end
    return v;
  endfunction

  // Bus monitor: event = {we, re, addr, data}; reads carry zero data.
  logic [15:0] ev_q[$];
  int          ev_cyc[$];
  logic [7:0]  rsp_q[$];
  int          rsp_cyc[$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      if (io_re || io_we) begin
        ev_q.push_back({io_we, io_re, io_a, io_we ? io_wd : 8'h00});
        ev_cyc.push_back(cyc);
        check("strobe_exclusive", {31'd0, io_re & io_we}, 32'd0);
        if (io_re) check("wd_zero_on_read", {24'd0, io_wd}, 32'd0);
      end else if (io_a != 6'd0 || io_wd != 8'h00) begin
        check("bus_idle_zero", {18'd0, io_a, io_wd}, 32'd0);
      end
      if (prev_stall)
        check("rsp_hold", {23'd0, rsp_valid, rsp_data}, {23'd0, 1'b1, prev_data});
      if (rsp_valid && rsp_ready) begin
        rsp_q.push_back(rsp_data);
        rsp_cyc.push_back(cyc);
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  int last_acc, acc_cmd, acc_last;

  task automatic send_byte(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = d;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("cmd_accept_timeout", 32'(n), 32'd0);
    last_acc = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [7:0] c, input logic [7:0] d0, input logic [7:0] d1,
                        input bit bp, input int hold);
    logic [15:0] exp_ev[$];
    logic [7:0]  exp_rsp[$];
    logic [5:0]  a, a1;
    int n, cnt;
    a  = c[5:0];
    a1 = a + 6'd1;
    ev_q.delete(); ev_cyc.delete(); rsp_q.delete(); rsp_cyc.delete();
    send_byte(c);
    acc_cmd = last_acc;
    if (c[7]) begin
      send_byte(d0);
      if (c[6]) begin
        send_byte(d1);
        exp_ev.push_back({2'b10, a1, d1});
        exp_ev.push_back({2'b10, a, d0});
        ref_wr(a1, d1);
        ref_wr(a, d0);
      end else begin
        exp_ev.push_back({2'b10, a, d0});
        ref_wr(a, d0);
      end
      acc_last = last_acc;
      repeat (3) @(posedge clk);
    end else begin
      exp_ev.push_back({2'b01, a, 8'h00});
      exp_rsp.push_back(ref_rd(a));
      if (c[6]) begin
        exp_ev.push_back({2'b01, a1, 8'h00});
        exp_rsp.push_back(ref_rd(a1));
      end
      n = c[6] ? 2 : 1;
      if (hold > 0) begin
        rsp_ready = 1'b0;
        repeat (hold) begin
          @(negedge clk);
          check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        end
        check("rsp_valid_stalled", {31'd0, rsp_valid}, 32'd1);
      end
      cnt = 0;
      while (rsp_q.size() < n && cnt < 300) begin
        @(posedge clk);
        #1;
        rsp_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        cnt++;
      end
      if (cnt >= 300) check("rsp_timeout", 32'(rsp_q.size()), 32'(n));
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
    end
    check("ev_count", 32'(ev_q.size()), 32'(exp_ev.size()));
    for (int i = 0; i < exp_ev.size() && i < ev_q.size(); i++)
      check("ev", {16'd0, ev_q[i]}, {16'd0, exp_ev[i]});
    check("rsp_count", 32'(rsp_q.size()), 32'(exp_rsp.size()));
    for (int i = 0; i < exp_rsp.size() && i < rsp_q.size(); i++)
      check("rsp", {24'd0, rsp_q[i]}, {24'd0, exp_rsp[i]});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      pmem[i]  = 8'($urandom);
      r_mem[i] = pmem[i];
    end

    // Reset held with traffic offered: everything quiet.
    cmd_valid = 1'b1;
    cmd_data  = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {6'd0, cmd_ready, rsp_valid, rsp_data, io_re, io_we, io_a, io_wd}, 32'd0);
    end
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // Single write: strobe the cycle after the data byte.
    do_cmd(8'h82, 8'h5A, 8'h00, 1'b0, 0);
    check("wr1_cycle", 32'(ev_cyc.size() > 0 ? ev_cyc[0] : -1), 32'(acc_last + 1));

    // Paired write to the timer: high (a=1) then low (a=0) on consecutive cycles.
    do_cmd(8'hC0, 8'h34, 8'h12, 1'b0, 0);
    check("pw_cycle0", 32'(ev_cyc.size() > 0 ? ev_cyc[0] : -1), 32'(acc_last + 1));
    check("pw_cycle1", 32'(ev_cyc.size() > 1 ? ev_cyc[1] : -1), 32'(acc_last + 2));
    check("timer_value", {16'd0, tcnt}, 32'h1234);

    // Paired read of timer loaded with 0xABCD.
    do_cmd(8'hC0, 8'hCD, 8'hAB, 1'b0, 0);
    do_cmd(8'h40, 8'h00, 8'h00, 1'b0, 0);
    check("pr_re_cycle0", 32'(ev_cyc.size() > 0 ? ev_cyc[0] : -1), 32'(acc_cmd + 1));
    check("pr_re_cycle1", 32'(ev_cyc.size() > 1 ? ev_cyc[1] : -1), 32'(acc_cmd + 2));
    check("pr_rsp_cycle", 32'(rsp_cyc.size() > 0 ? rsp_cyc[0] : -1), 32'(acc_cmd + 3));
    check("pr_rsp_lo", {24'd0, rsp_q.size() > 0 ? rsp_q[0] : 8'hxx}, 32'hCD);
    check("pr_rsp_hi", {24'd0, rsp_q.size() > 1 ? rsp_q[1] : 8'hxx}, 32'hAB);

    // Backpressure with address wrap 63 -> 0.
    do_cmd(8'h7F, 8'h00, 8'h00, 1'b0, 5);

    // Reset between the two data bytes of a paired write.
    ev_q.delete();
    send_byte(8'hC5);
    send_byte(8'h11);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("no_we_after_abort", 32'(ev_q.size()), 32'd0);
    do_cmd(8'h05, 8'h00, 8'h00, 1'b0, 0);

    // Random traffic with random response backpressure.
    for (int i = 0; i < 40; i++)
      do_cmd(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
